// File: rtl/cd_cfg_arbiter_pkg.sv
// Shared definitions for the clock-divider config arbiter: default widths,
// timing defaults and the FSM state encoding.
package cd_cfg_arbiter_pkg;

   localparam int CD_WIDTH_CONFIG_ADDR = 2;
   localparam int CD_WIDTH_CONFIG_DATA = 8;
   localparam int CD_SETTLE_CYCLES     = 4;
   localparam int CD_TIMEOUT_CYCLES    = 255;
   localparam int CD_TIMER_W           = 8;

   localparam logic [1:0] CD_ST_IDLE   = 2'd0;
   localparam logic [1:0] CD_ST_ISSUE  = 2'd1;
   localparam logic [1:0] CD_ST_SETTLE = 2'd2;
   localparam logic [1:0] CD_ST_DONE   = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = CD_ST_IDLE,
      ST_ISSUE  = CD_ST_ISSUE,
      ST_SETTLE = CD_ST_SETTLE,
      ST_DONE   = CD_ST_DONE
   } cd_state_e;

endpackage

// File: rtl/cd_cfg_arbiter_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, on contention the one
// that was not granted last time wins.
module cd_rr_pick (
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = valid_i;
      if (valid_i == 2'b11) begin
         grant_o = last_grant_i ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/cd_cfg_arbiter.sv
// Arbitrates two config writers onto the clock-divider config port, waits for
// the dividers to accept and settle, then reports done/err to the winner.
module cd_cfg_arbiter
   import cd_cfg_arbiter_pkg::*;
#(
   parameter int WIDTH_CONFIG_ADDR = CD_WIDTH_CONFIG_ADDR,
   parameter int WIDTH_CONFIG_DATA = CD_WIDTH_CONFIG_DATA,
   parameter int SETTLE_CYCLES     = CD_SETTLE_CYCLES,
   parameter int TIMEOUT_CYCLES    = CD_TIMEOUT_CYCLES
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         r0_valid,
   input  logic [WIDTH_CONFIG_ADDR-1:0] r0_addr,
   input  logic [WIDTH_CONFIG_DATA-1:0] r0_data,
   output logic                         r0_ready,
   output logic                         r0_done,
   output logic                         r0_err,
   input  logic                         r1_valid,
   input  logic [WIDTH_CONFIG_ADDR-1:0] r1_addr,
   input  logic [WIDTH_CONFIG_DATA-1:0] r1_data,
   output logic                         r1_ready,
   output logic                         r1_done,
   output logic                         r1_err,
   output logic [WIDTH_CONFIG_ADDR-1:0] c_addr,
   output logic [WIDTH_CONFIG_DATA-1:0] c_data,
   output logic                         c_valid,
   input  logic                         c_ready,
   output logic                         busy
);

   localparam logic [CD_TIMER_W-1:0] TIMEOUT_LAST = CD_TIMER_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CD_TIMER_W-1:0] SETTLE_LAST  =
      CD_TIMER_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   cd_state_e                    state_q, state_d;
   logic [CD_TIMER_W-1:0]        timer_q, timer_d;
   logic                         err_q, err_d;
   logic                         last_grant_q, last_grant_d;
   logic                         grant_q, grant_d;
   logic [WIDTH_CONFIG_ADDR-1:0] addr_q, addr_d;
   logic [WIDTH_CONFIG_DATA-1:0] data_q, data_d;

   logic [1:0] pick_grant;
   logic [1:0] ready_vec;
   logic       issue_act;
   logic       done_act;

   cd_rr_pick u_rr_pick (
      .valid_i      ({r1_valid, r0_valid}),
      .last_grant_i (last_grant_q),
      .grant_o      (pick_grant)
   );

   // NOTE: every signal driven here gets its default first so no path leaves
   // it unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      err_d        = err_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      addr_d       = addr_q;
      data_d       = data_q;
      ready_vec    = 2'b00;
      issue_act    = 1'b0;
      done_act     = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (pick_grant != 2'b00) begin
               ready_vec    = pick_grant;
               grant_d      = pick_grant[1];
               last_grant_d = pick_grant[1];
               addr_d       = pick_grant[1] ? r1_addr : r0_addr;
               data_d       = pick_grant[1] ? r1_data : r0_data;
               err_d        = 1'b0;
               timer_d      = '0;
               state_d      = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            issue_act = 1'b1;
            if (c_ready) begin
               timer_d = '0;
               state_d = (SETTLE_CYCLES == 0) ? ST_DONE : ST_SETTLE;
            end else if (timer_q == TIMEOUT_LAST) begin
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_SETTLE: begin
            if (timer_q == SETTLE_LAST) begin
               state_d = ST_DONE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_DONE: begin
            done_act = 1'b1;
            timer_d  = '0;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         err_q        <= 1'b0;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         addr_q       <= '0;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         err_q        <= err_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
      end
   end

   // Outputs are masked by rst so nothing escapes during the reset cycle,
   // including a done pulse from a transaction being aborted.
   assign r0_ready = ready_vec[0] & ~rst;
   assign r1_ready = ready_vec[1] & ~rst;
   assign c_valid  = issue_act & ~rst;
   assign c_addr   = c_valid ? addr_q : '0;
   assign c_data   = c_valid ? data_q : '0;
   assign busy     = (state_q != ST_IDLE) & ~rst;
   assign r0_done  = done_act & ~grant_q & ~rst;
   assign r1_done  = done_act & grant_q & ~rst;
   assign r0_err   = r0_done & err_q;
   assign r1_err   = r1_done & err_q;

endmodule

// File: doc/cd_cfg_arbiter.md
CD_CFG_ARBITER -- requirements
Module: cd_cfg_arbiter

Interface
REQ-001 Parameter WIDTH_CONFIG_ADDR, default 2, SHALL set the config address width.
REQ-002 Parameter WIDTH_CONFIG_DATA, default 8, SHALL set the config data width.
REQ-003 Parameter SETTLE_CYCLES, default 4, range 0..255, SHALL set the post-accept wait while the divider counters restart.
REQ-004 Parameter TIMEOUT_CYCLES, default 255, range 1..255, SHALL set the maximum ISSUE wait for c_ready.
REQ-005 clk  in  1  single clock, shared with the clock divider config port.
REQ-006 rst  in  1  reset; synchronous, active-high.
REQ-007 rN_valid  in  1  (N=0,1) requester N has a write pending; held with addr/data stable until rN_ready.
REQ-008 rN_addr  in  WIDTH_CONFIG_ADDR  requester N config address.
REQ-009 rN_data  in  WIDTH_CONFIG_DATA  requester N config data.
REQ-010 rN_ready  out  1  request latched this cycle.
REQ-011 rN_done  out  1  one-cycle pulse: requester N transaction finished.
REQ-012 rN_err  out  1  one-cycle pulse, coincident with rN_done, on timeout.
REQ-013 c_addr  out  WIDTH_CONFIG_ADDR  to divider config port.
REQ-014 c_data  out  WIDTH_CONFIG_DATA  to divider config port.
REQ-015 c_valid  out  1  to divider config port.
REQ-016 c_ready  in  1  from divider config port (all divider counters configured).
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, SETTLE, DONE.
REQ-019 In IDLE, rN_ready SHALL be combinationally high when rN_valid is high and N is the grant; next state ISSUE, rN_addr/rN_data and grant ID latched.
REQ-020 Grant SHALL be round-robin: single valid wins; both valid -> requester other than last_grant; last_grant updates on each latch.
REQ-021 In ISSUE, c_valid SHALL be 1 with latched addr/data; c_addr/c_data SHALL stay stable until leaving ISSUE.
REQ-022 ISSUE with c_ready=1 -> SETTLE (or DONE if SETTLE_CYCLES=0); c_valid low from next cycle.
REQ-023 An 8-bit timer SHALL count ISSUE cycles; on reaching TIMEOUT_CYCLES without c_ready -> DONE with error flag set.
REQ-024 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then -> DONE.
REQ-025 DONE SHALL last one cycle, pulse rN_done (and rN_err if error) for latched N only, then -> IDLE.
REQ-026 rN_ready SHALL be 0 outside IDLE; requests arriving while busy wait.
REQ-027 Minimum transaction: latch edge, 1 ISSUE cycle, SETTLE_CYCLES, 1 DONE cycle; back-to-back grant possible in the IDLE cycle after DONE.
REQ-028 c_addr/c_data SHALL be 0 whenever c_valid is 0.

Reset
REQ-029 rst SHALL force IDLE, timer=0, error flag=0, last_grant=1 (requester 0 wins first contention), latched addr/data=0.
REQ-030 During/after reset all outputs SHALL be 0; reset mid-transaction SHALL produce no done/err pulse.

Structure
REQ-031 State encoding localparams and default widths SHALL live in the shared CD parameter include file.
REQ-032 Round-robin selection SHALL be sub-module cd_rr_pick (inputs 2 valids + last_grant, outputs grant one-hot); all else in one module.

Verification
REQ-033 r0 writes addr=1 data=0x5A, c_ready=1, SETTLE=4 -> r0_ready cycle 0, c_valid cycle 1 with 1/0x5A, r0_done cycle 6, r0_err=0.
REQ-034 r0,r1 valid together for 3 transactions -> grant order r0,r1,r0; no overlap of c_valid.
REQ-035 c_ready held 0, TIMEOUT=10 -> c_valid for 10 cycles, then r0_done=r0_err=1 one cycle, busy drops.
REQ-036 c_ready rises on 3rd ISSUE cycle -> SETTLE entered next edge, no err.
REQ-037 rst asserted during SETTLE -> next cycle IDLE, busy=0, no r0_done pulse; following request granted normally.
REQ-038 SETTLE_CYCLES=0 -> DONE directly after accepting ISSUE cycle; r1 valid while busy -> r1_ready only after DONE.
